// File: rtl/bp_network_pkg.sv
// Shared types and helpers for the network transmit arbiter: flit header layout,
// transmit FSM states and flits-per-message computation.
package bp_network_pkg;

  localparam int unsigned dest_id_width_gp = 4;
  localparam int unsigned src_id_width_gp  = 4;

  typedef struct packed {
    logic [dest_id_width_gp-1:0] dest_id;
    logic [src_id_width_gp-1:0]  src_id;
  } flit_header_s;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  function automatic int unsigned num_packets(input int unsigned msg_width,
                                              input int unsigned pkt_width);
    return (msg_width + pkt_width - 1) / pkt_width;
  endfunction

endpackage

// File: rtl/bp_network_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer,
// pointer moves past the winner only when the caller strobes advance.
module bp_network_rr_arbiter #(
  parameter int num_src_p = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_src_p-1:0]         reqs,
  input  logic                         advance,
  output logic [num_src_p-1:0]         grant,
  output logic [$clog2(num_src_p)-1:0] grant_id
);

  localparam int id_width_lp  = $clog2(num_src_p);
  localparam int sum_width_lp = id_width_lp + 1;
  localparam logic [sum_width_lp-1:0] num_src_lp = sum_width_lp'(num_src_p);
  localparam logic [id_width_lp-1:0]  last_id_lp = id_width_lp'(num_src_p - 1);

  logic [id_width_lp-1:0]  ptr_r;
  logic                    found_s;
  logic                    hit_s;
  logic [sum_width_lp-1:0] sum_s;
  logic [id_width_lp-1:0]  idx_s;

  // First requester at or after ptr_r, wrapping modulo num_src_p
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    sum_s    = '0;
    idx_s    = '0;
    for (int i = 0; i < num_src_p; i++) begin
      sum_s         = {1'b0, ptr_r} + sum_width_lp'(i);
      idx_s         = (sum_s >= num_src_lp) ? id_width_lp'(sum_s - num_src_lp)
                                            : sum_s[id_width_lp-1:0];
      hit_s         = ~found_s & reqs[idx_s];
      grant[idx_s]  = grant[idx_s] | hit_s;
      grant_id      = hit_s ? idx_s : grant_id;
      found_s       = found_s | hit_s;
    end
  end

  // Pointer moves only on an actual grant, so idle cycles keep fairness order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (grant_id == last_id_lp) ? '0 : grant_id + id_width_lp'(1);
    end
  end

endmodule

// File: rtl/bp_network_tx_arbiter.sv
// Shares one network injection port among num_src_p message sources: grants one
// message round-robin, then streams it out as header-tagged flits.
module bp_network_tx_arbiter
  import bp_network_pkg::*;
#(
  parameter  int num_src_p           = 4,
  parameter  int dest_id_width_p     = dest_id_width_gp,
  parameter  int src_id_width_p      = src_id_width_gp,
  parameter  int source_data_width_p = 64,
  parameter  int packet_data_width_p = 16,
  localparam int num_packets_p       = num_packets(source_data_width_p, packet_data_width_p),
  localparam int flit_width_lp       = dest_id_width_p + src_id_width_p + packet_data_width_p,
  localparam int grant_width_lp      = $clog2(num_src_p)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_src_p-1:0]                     valid_i,
  input  logic [num_src_p*source_data_width_p-1:0] data_i,
  output logic [num_src_p-1:0]                     ready_o,
  output logic                                     valid_o,
  output logic [flit_width_lp-1:0]                 data_o,
  output logic                                     last_o,
  output logic [grant_width_lp-1:0]                grant_id_o,
  input  logic                                     yumi_i
);

  localparam int padded_width_lp = num_packets_p * packet_data_width_p;
  localparam int cnt_width_lp    = (num_packets_p > 1) ? $clog2(num_packets_p) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_packets_p - 1);

  tx_state_e                    state_r, state_s;
  logic [cnt_width_lp-1:0]      cnt_r, cnt_s;
  logic [padded_width_lp-1:0]   msg_r, msg_s;
  flit_header_s                 hdr_r, hdr_s;
  logic [grant_width_lp-1:0]    grant_id_r, grant_id_s;
  logic                         valid_r, valid_s;
  logic                         last_r, last_s;
  logic [packet_data_width_p-1:0] payload_r, payload_s;

  logic [num_src_p-1:0]           arb_reqs_s;
  logic [num_src_p-1:0]           arb_grant_s;
  logic [grant_width_lp-1:0]      arb_id_s;
  logic                           advance_s;
  logic [source_data_width_p-1:0] sel_msg_s;
  logic [padded_width_lp-1:0]     sel_ext_s;
  logic [cnt_width_lp-1:0]        cnt_inc_s;
  logic [packet_data_width_p-1:0] next_payload_s;

  // Sources only compete while no message is in flight
  assign arb_reqs_s = (state_r == IDLE) ? valid_i : '0;

  bp_network_rr_arbiter #(
    .num_src_p (num_src_p)
  ) u_rr_arbiter (
    .clk      (clk_i),
    .reset    (reset_i),
    .reqs     (arb_reqs_s),
    .advance  (advance_s),
    .grant    (arb_grant_s),
    .grant_id (arb_id_s)
  );

  assign ready_o    = arb_grant_s & {num_src_p{~reset_i}};
  assign valid_o    = valid_r;
  assign last_o     = last_r;
  assign data_o     = {hdr_r, payload_r};
  assign grant_id_o = grant_id_r;

  // One-hot select of the winning message, zero-extended to whole flits
  always_comb begin
    sel_msg_s = '0;
    for (int i = 0; i < num_src_p; i++) begin
      sel_msg_s = sel_msg_s
                | ({source_data_width_p{arb_grant_s[i]}}
                   & data_i[i*source_data_width_p +: source_data_width_p]);
    end
    sel_ext_s = '0;
    sel_ext_s[source_data_width_p-1:0] = sel_msg_s;
  end

  // Payload of the flit following the current one
  always_comb begin
    cnt_inc_s      = cnt_r + cnt_width_lp'(1);
    next_payload_s = '0;
    for (int k = 0; k < num_packets_p; k++) begin
      next_payload_s = (cnt_inc_s == cnt_width_lp'(k))
                     ? msg_r[k*packet_data_width_p +: packet_data_width_p]
                     : next_payload_s;
    end
  end

  // Transmit FSM next-state and registered output values
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    msg_s      = msg_r;
    hdr_s      = hdr_r;
    grant_id_s = grant_id_r;
    valid_s    = valid_r;
    last_s     = last_r;
    payload_s  = payload_r;
    advance_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (|arb_reqs_s) begin
          advance_s     = 1'b1;
          state_s       = SEND;
          cnt_s         = '0;
          msg_s         = sel_ext_s;
          hdr_s.dest_id = sel_msg_s[source_data_width_p-1 -: dest_id_width_p];
          hdr_s.src_id  = sel_msg_s[source_data_width_p-dest_id_width_p-1 -: src_id_width_p];
          grant_id_s    = arb_id_s;
          valid_s       = 1'b1;
          last_s        = (num_packets_p == 1);
          payload_s     = sel_ext_s[packet_data_width_p-1:0];
        end else begin
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if (last_r) begin
            state_s   = IDLE;
            cnt_s     = '0;
            valid_s   = 1'b0;
            last_s    = 1'b0;
            payload_s = '0;
            hdr_s     = '0;
          end else begin
            cnt_s     = cnt_inc_s;
            payload_s = next_payload_s;
            last_s    = (cnt_inc_s == last_cnt_lp);
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any message in flight
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      msg_r      <= '0;
      hdr_r      <= '0;
      grant_id_r <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      payload_r  <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      msg_r      <= msg_s;
      hdr_r      <= hdr_s;
      grant_id_r <= grant_id_s;
      valid_r    <= valid_s;
      last_r     <= last_s;
      payload_r  <= payload_s;
    end
  end

endmodule

// File: tb/tb_bp_network_tx_arbiter.sv
// Self-checking bench: table of arbitration vectors with a flit scoreboard, plus
// hand-written sequences for async reset and a padded 40-bit message.
module tb_bp_network_tx_arbiter;

  typedef struct {
    logic [3:0] mask;
    int         stall_at;
    int         stall_len;
    int         winner;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic [1:0]  gid;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   valid;
  logic [255:0] data;
  logic [3:0]   ready;
  logic         vo;
  logic [23:0]  dout;
  logic         last;
  logic [1:0]   gid;
  logic         yumi;

  logic [1:0]   v40;
  logic [79:0]  d40;
  logic [1:0]   r40;
  logic         vo40;
  logic [23:0]  do40;
  logic         l40;
  logic         g40;
  logic         y40;

  int tests = 0;
  int fails = 0;

  logic [63:0] src_msg [4];
  vec_t        vecs [11];
  exp_t        exp_q [$];

  always #5 clk = ~clk;

  bp_network_tx_arbiter u_dut (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .data_i(data), .ready_o(ready),
    .valid_o(vo), .data_o(dout), .last_o(last), .grant_id_o(gid), .yumi_i(yumi)
  );

  bp_network_tx_arbiter #(.num_src_p(2), .source_data_width_p(40)) u_dut40 (
    .clk_i(clk), .reset_i(rst), .valid_i(v40), .data_i(d40), .ready_o(r40),
    .valid_o(vo40), .data_o(do40), .last_o(l40), .grant_id_o(g40), .yumi_i(y40)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_flit(input logic [63:0] m, input int k);
    logic [63:0] s;
    s = m >> (16 * k);
    return {m[63:56], s[15:0]};
  endfunction

  // Present one arbitration round, push the winner's flits, drain them with yumi
  task automatic run_msg(input logic [3:0] mask, input int stall_at,
                         input int stall_len, input int winner);
    exp_t e;
    int   k;
    valid = mask;
    data  = {src_msg[3], src_msg[2], src_msg[1], src_msg[0]};
    #1;
    check("idle_gap_valid", vo, 0);
    if (winner < 0) begin
      repeat (3) begin
        check("idle_ready", ready, 0);
        @(posedge clk); #1;
        check("idle_valid", vo, 0);
      end
      return;
    end
    check("grant_onehot", ready, 4'b0001 << winner);
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back('{data: exp_flit(src_msg[winner], f), last: (f == 3), gid: 2'(winner)});
    end
    @(posedge clk); #1;
    check("send_ready_zero", ready, 0);
    while (exp_q.size() > 0) begin
      e = exp_q[0];
      k = 4 - exp_q.size();
      if (k == stall_at) begin
        yumi = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          check("stall_valid", vo, 1);
          check("stall_data", dout, e.data);
          check("stall_last", last, e.last);
        end
      end
      check("protocol_yumi_valid", vo, 1);
      check("flit_data", dout, e.data);
      check("flit_last", last, e.last);
      check("flit_gid", gid, e.gid);
      yumi = 1'b1;
      @(posedge clk); #1;
      yumi = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    src_msg[0] = 64'h9A00_0000_0000_BEEF;
    src_msg[1] = 64'h5B12_3456_789A_BCDE;
    src_msg[2] = 64'hC3F0_0F0F_A5A5_1234;
    src_msg[3] = 64'h7E01_8000_FFFF_0001;

    vecs[0]  = '{4'hF, -1, 0,  0};
    vecs[1]  = '{4'hF, -1, 0,  1};
    vecs[2]  = '{4'hF, -1, 0,  2};
    vecs[3]  = '{4'hF, -1, 0,  3};
    vecs[4]  = '{4'hF, -1, 0,  0};
    vecs[5]  = '{4'h1, -1, 0,  0};
    vecs[6]  = '{4'h2,  1, 5,  1};
    vecs[7]  = '{4'h0, -1, 0, -1};
    vecs[8]  = '{4'hC, -1, 0,  2};
    vecs[9]  = '{4'h4, -1, 0,  2};
    vecs[10] = '{4'h4,  2, 3,  2};

    rst = 1'b1; valid = '0; data = '0; yumi = 1'b0;
    v40 = '0; d40 = '0; y40 = 1'b0;
    #12;
    check("reset_valid", vo, 0);
    check("reset_data", dout, 0);
    check("reset_last", last, 0);
    check("reset_gid", gid, 0);
    check("reset_ready", ready, 0);
    check("reset_valid40", vo40, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 11; v++) begin
      run_msg(vecs[v].mask, vecs[v].stall_at, vecs[v].stall_len, vecs[v].winner);
    end

    // Async reset while flit 2 of src1's message is on the output
    valid = 4'b0010;
    #1;
    check("rst_seq_grant", ready, 4'b0010);
    @(posedge clk); #1;
    valid = 4'b0000;
    check("rst_seq_flit0", dout, exp_flit(src_msg[1], 0));
    yumi = 1'b1;
    @(posedge clk); #1;
    check("rst_seq_flit1", dout, exp_flit(src_msg[1], 1));
    @(posedge clk); #1;
    yumi = 1'b0;
    check("rst_seq_flit2", dout, exp_flit(src_msg[1], 2));
    check("rst_seq_gid_before", gid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", vo, 0);
    check("async_rst_data", dout, 0);
    check("async_rst_last", last, 0);
    check("async_rst_gid", gid, 0);
    check("async_rst_ready", ready, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_msg(4'hF, -1, 0, 0);
    valid = '0;

    // 40-bit message: three flits, top 8 payload bits of the last one padded
    v40 = 2'b10;
    d40 = {40'hB7C1234567, 40'h0};
    #1;
    check("pad_grant", r40, 2'b10);
    @(posedge clk); #1;
    v40 = 2'b00;
    for (int f = 0; f < 3; f++) begin
      logic [23:0] e40;
      e40 = (f == 0) ? 24'hB74567 : (f == 1) ? 24'hB7C123 : 24'hB700B7;
      check("pad_valid", vo40, 1);
      check("pad_data", do40, e40);
      check("pad_last", l40, (f == 2));
      check("pad_gid", g40, 1);
      if (f == 2) begin
        check("pad_zero_bits", do40[15:8], 0);
      end
      y40 = 1'b1;
      @(posedge clk); #1;
      y40 = 1'b0;
    end
    check("pad_done_valid", vo40, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
